// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmit controller:
// FSM state encoding, line-mux select codes and the data-width legality check.
`ifndef UART_PKG_SV
`define UART_PKG_SV

// True when a data width is one the controller supports (5..9 bits).
`define UART_DATA_WIDTH_LEGAL(dw) (((dw) >= 5) && ((dw) <= 9))

package uart_pkg;

  // Binary-encoded controller states; encodings 6 and 7 are unused.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5
  } uart_state_e;

  // Line mux select codes.
  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_START = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // Line mux select driven while in a given state; unused codes show idle.
  function automatic logic [1:0] sel_of(uart_state_e st);
    case (st)
      START:   return SEL_START;
      DATA:    return SEL_DATA;
      PARITY:  return SEL_PAR;
      default: return SEL_IDLE;
    endcase
  endfunction

endpackage

`endif

// File: rtl/uart_tx_ctrl_param_bit_cnt.sv
// Data-bit counter for the UART transmit controller. Counts 0..DATA_WIDTH-1,
// wraps to 0 after the last bit and flags the last bit with LAST.
module uart_bit_cnt
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  output logic [CNT_W-1:0] CNT,
  output logic             LAST
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DATA_WIDTH - 1);

  assign LAST = (CNT == LAST_VAL);

  // Clear on reset or frame start, advance once per shifted bit, wrap after the last.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      CNT <= '0;
    end else if (EN) begin
      CNT <= LAST ? '0 : CNT + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl_param.sv
// Parametrised UART transmit control FSM: sequences start, DATA_WIDTH data
// bits, optional parity and one or two stop bits on an external baud TICK.
// Optional feature macro UART_TX_B2B_EN: when defined, a new request seen on
// the final stop TICK starts the next frame immediately with no idle cycle.
module uart_tx_ctrl_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       STOP2,
  output logic       LOAD,
  output logic       SHIFT,
  output logic [1:0] SEL,
  output logic       BUSY,
  output logic       DONE
);

  if (!`UART_DATA_WIDTH_LEGAL(DATA_WIDTH)) begin : g_width_check
    $error("uart_tx_ctrl_param: DATA_WIDTH must be in 5..9");
  end

  uart_state_e      state;
  uart_state_e      state_nxt;
  logic             par_en_q;
  logic             stop2_q;
  logic             done_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_last;
  logic             accept;
  logic             final_stop;
  logic             frame_end;
  logic             b2b_load;

  assign accept     = (state == IDLE) && DATA_VALID;
  assign final_stop = (state == STOP_2) || ((state == STOP_1) && !stop2_q);
  assign frame_end  = final_stop && TICK;

`ifdef UART_TX_B2B_EN
  assign b2b_load = frame_end && DATA_VALID;
`else
  assign b2b_load = 1'b0;
`endif

  // LOAD and SHIFT are combinational so the serializer acts on the same edge
  // the FSM moves; DONE also pulses combinationally on a back-to-back reload.
  assign LOAD  = accept || b2b_load;
  assign SHIFT = (state == DATA) && TICK;
  assign SEL   = sel_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q || b2b_load;

  uart_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (LOAD),
    .EN   (SHIFT),
    .CNT  (bit_cnt),
    .LAST (cnt_last)
  );

  // Next-state logic: IDLE reacts to requests at once, all others wait for TICK.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DATA_VALID) state_nxt = START;
      START:   if (TICK) state_nxt = DATA;
      DATA:    if (TICK && cnt_last) state_nxt = par_en_q ? PARITY : STOP_1;
      PARITY:  if (TICK) state_nxt = STOP_1;
      STOP_1:  if (TICK) state_nxt = stop2_q ? STOP_2 : IDLE;
      STOP_2:  if (TICK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (b2b_load) begin
      state_nxt = START;
    end
  end

  // State, registered Moore outputs, end-of-frame pulse and per-frame options.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      sel_q    <= SEL_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_of(state_nxt);
      busy_q <= (state_nxt != IDLE);
      done_q <= frame_end && !b2b_load;
      if (LOAD) begin
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl_param.sv
// Bench for uart_tx_ctrl_param: three widths (5, 8, 9) share one stimulus and
// are compared every cycle against a frame-position model.
module tb_uart_tx_ctrl_param;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK = 1'b0;
  logic DATA_VALID = 1'b0;
  logic PAR_EN = 1'b0;
  logic STOP2 = 1'b0;

  logic       load_w  [3];
  logic       shift_w [3];
  logic [1:0] sel_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];

  int W_A[3]       = '{5, 8, 9};
  int EXP_SHIFT[3] = '{5, 8, 9};
  int EXP_T1[3]    = '{7, 10, 11};
  int EXP_T2[3]    = '{9, 12, 13};
  int EXP_CMAX[3]  = '{4, 7, 8};

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit tick_on = 1'b0;

  // model: frame position in baud periods counted from START
  bit m_busy[3];
  int m_pos[3];
  bit m_par[3];
  bit m_st2[3];
  bit m_done[3];

  // statistics gathered by the compare process
  int st_shift[3], st_tbusy[3], st_sel11[3], st_done[3], st_load[3];
  int st_idle_done[3], st_load_done[3];
  int cnt_max[3];

  uart_tx_ctrl_param #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .STOP2(STOP2), .LOAD(load_w[0]), .SHIFT(shift_w[0]), .SEL(sel_w[0]),
    .BUSY(busy_w[0]), .DONE(done_w[0]));
  uart_tx_ctrl_param #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .STOP2(STOP2), .LOAD(load_w[1]), .SHIFT(shift_w[1]), .SEL(sel_w[1]),
    .BUSY(busy_w[1]), .DONE(done_w[1]));
  uart_tx_ctrl_param #(.DATA_WIDTH(9)) dut9 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .STOP2(STOP2), .LOAD(load_w[2]), .SHIFT(shift_w[2]), .SEL(sel_w[2]),
    .BUSY(busy_w[2]), .DONE(done_w[2]));

  always #5 CLK = ~CLK;

  function automatic int frame_len(int i);
    return 2 + W_A[i] + int'(m_par[i]) + int'(m_st2[i]);
  endfunction

  function automatic logic [1:0] exp_sel(int i);
    if (!m_busy[i]) return 2'b00;
    if (m_pos[i] == 0) return 2'b01;
    if (m_pos[i] <= W_A[i]) return 2'b10;
    if (m_par[i] && m_pos[i] == W_A[i] + 1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check(string nm, int inst, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s w=%0d t=%0t got %0d expected %0d", nm, W_A[inst], $time, act, exp);
    end
  endtask

  // Model update on each rising edge from the inputs seen at that edge.
  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        m_busy[i] <= 1'b0; m_pos[i] <= 0; m_done[i] <= 1'b0;
        m_par[i] <= 1'b0; m_st2[i] <= 1'b0;
      end else if (!m_busy[i]) begin
        m_done[i] <= 1'b0;
        if (DATA_VALID) begin
          m_busy[i] <= 1'b1; m_pos[i] <= 0; m_par[i] <= PAR_EN; m_st2[i] <= STOP2;
        end
      end else begin
        m_done[i] <= 1'b0;
        if (TICK) begin
          if (m_pos[i] == frame_len(i) - 1) begin
`ifdef UART_TX_B2B_EN
            if (DATA_VALID) begin
              m_pos[i] <= 0; m_par[i] <= PAR_EN; m_st2[i] <= STOP2;
            end else begin
              m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
            end
`else
            m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
`endif
          end else begin
            m_pos[i] <= m_pos[i] + 1;
          end
        end
      end
    end
  end

  // Compare process: every falling edge once checking is enabled.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          bit e_final, e_b2b, e_load, e_shift, e_done;
          e_final = m_busy[i] && TICK && (m_pos[i] == frame_len(i) - 1);
`ifdef UART_TX_B2B_EN
          e_b2b = e_final && DATA_VALID;
`else
          e_b2b = 1'b0;
`endif
          e_load  = (!m_busy[i] && DATA_VALID) || e_b2b;
          e_shift = m_busy[i] && TICK && m_pos[i] >= 1 && m_pos[i] <= W_A[i];
          e_done  = m_done[i] || e_b2b;
          check("LOAD", i, load_w[i], e_load);
          check("SHIFT", i, shift_w[i], e_shift);
          check("SEL", i, sel_w[i], exp_sel(i));
          check("BUSY", i, busy_w[i], m_busy[i]);
          check("DONE", i, done_w[i], e_done);
          st_shift[i] += shift_w[i];
          st_tbusy[i] += (TICK && busy_w[i]);
          st_sel11[i] += (sel_w[i] == 2'b11);
          st_done[i]  += done_w[i];
          st_load[i]  += load_w[i];
          st_idle_done[i] += (done_w[i] && !busy_w[i]);
          st_load_done[i] += (done_w[i] && load_w[i]);
        end
        if (int'(dut5.bit_cnt) > cnt_max[0]) cnt_max[0] = int'(dut5.bit_cnt);
        if (int'(dut8.bit_cnt) > cnt_max[1]) cnt_max[1] = int'(dut8.bit_cnt);
        if (int'(dut9.bit_cnt) > cnt_max[2]) cnt_max[2] = int'(dut9.bit_cnt);
      end
    end
  end

  // Baud tick: one CLK pulse every 4 CLK while enabled.
  initial begin
    int ph = 0;
    forever begin
      @(posedge CLK);
      #1;
      ph = (ph + 1) % 4;
      TICK = tick_on && (ph == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      st_shift[i] = 0; st_tbusy[i] = 0; st_sel11[i] = 0; st_done[i] = 0;
      st_load[i] = 0; st_idle_done[i] = 0; st_load_done[i] = 0;
    end
  endtask

  task automatic pulse_dv();
    DATA_VALID = 1'b1;
    step(1);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && k < 400) begin
      step(1);
      k++;
    end
    if (k >= 400) check("wait_idle_timeout", 1, k, 0);
    step(2);
  endtask

  task automatic wait_shifts(int n);
    int k = 0;
    while (st_shift[1] < n && k < 400) begin
      step(1);
      k++;
    end
    if (k >= 400) check("wait_shift_timeout", 1, k, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cnt_max[i] = 0;
    clear_stats();
    step(2);
    chk_en = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      check("rst_LOAD", i, load_w[i], 0);
      check("rst_SHIFT", i, shift_w[i], 0);
      check("rst_SEL", i, sel_w[i], 0);
      check("rst_BUSY", i, busy_w[i], 0);
      check("rst_DONE", i, done_w[i], 0);
    end
    step(1);
    RST = 1'b0;
    tick_on = 1'b1;
    step(3);

    // basic frame, no parity, one stop bit
    clear_stats();
    pulse_dv();
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      check("t1_shifts", i, st_shift[i], EXP_SHIFT[i]);
      check("t1_busy_ticks", i, st_tbusy[i], EXP_T1[i]);
      check("t1_done", i, st_done[i], 1);
      check("t1_load", i, st_load[i], 1);
      check("t1_sel11", i, st_sel11[i], 0);
    end

    // parity + two stop bits; options dropped right after acceptance
    clear_stats();
    PAR_EN = 1'b1; STOP2 = 1'b1;
    pulse_dv();
    PAR_EN = 1'b0; STOP2 = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      check("t2_shifts", i, st_shift[i], EXP_SHIFT[i]);
      check("t2_busy_ticks", i, st_tbusy[i], EXP_T2[i]);
      check("t2_sel11_cycles", i, st_sel11[i], 4);
      check("t2_done", i, st_done[i], 1);
    end

    // reset mid-DATA after 3 shifts
    clear_stats();
    pulse_dv();
    wait_shifts(3);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    @(negedge CLK);
    check("t4_busy_after_rst", 1, busy_w[1], 0);
    check("t4_sel_after_rst", 1, sel_w[1], 0);
    check("t4_done_after_rst", 1, done_w[1], 0);
    step(20);
    for (int i = 0; i < 3; i++) check("t4_no_done", i, st_done[i], 0);
    clear_stats();
    pulse_dv();
    wait_idle();
    for (int i = 0; i < 3; i++) check("t4_refrm_shifts", i, st_shift[i], EXP_SHIFT[i]);

    // DATA_VALID held high across frames
    clear_stats();
    DATA_VALID = 1'b1;
    begin
      int k = 0;
      while (st_done[1] < 2 && k < 400) begin
        step(1);
        k++;
      end
      if (k >= 400) check("t5_timeout", 1, k, 0);
    end
    begin
      int idle_done, load_done;
      idle_done = st_idle_done[1];
      load_done = st_load_done[1];
      DATA_VALID = 1'b0;
`ifdef UART_TX_B2B_EN
      check("t5_idle_done", 1, idle_done, 0);
`else
      check("t5_idle_done", 1, idle_done, 2);
`endif
      check("t5_load_with_done", 1, load_done, 2);
    end
    wait_idle();

    // PAR_EN raised during DATA affects only the next frame
    clear_stats();
    PAR_EN = 1'b0;
    pulse_dv();
    wait_shifts(2);
    PAR_EN = 1'b1;
    wait_idle();
    for (int i = 0; i < 3; i++) check("t6_no_parity", i, st_sel11[i], 0);
    clear_stats();
    pulse_dv();
    PAR_EN = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) check("t6_next_parity", i, st_sel11[i], 4);

    for (int i = 0; i < 3; i++) check("cnt_max", i, cnt_max[i], EXP_CMAX[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
